// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   rf_state_e : clear-sweep FSM states (RF_IDLE, RF_SWEEP)
//   RF_DW      : default data width
//   RF_DEPTH   : default number of entries
//   rf_aw()    : ceil(log2(depth)), used to derive address widths
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  // Constant-bounded loop so it elaborates as a constant function.
  // Depth is at least 2, so the result is at least 1.
  function automatic int rf_aw(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: walks every writable entry of the register file once,
// issuing one zero-write per cycle, so architectural state can be flushed
// without a reset.
//   clk_i      : clock
//   rst_i      : synchronous active-low reset
//   clr_i      : single-cycle pulse that starts a sweep (ignored while sweeping)
//   busy_o     : registered, high for the whole sweep
//   clr_we_o   : zero-write strobe toward the storage array
//   clr_addr_o : entry being cleared this cycle
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = rf_aw(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  // Entry 0 never holds data when it is hardwired, so the sweep skips it.
  localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  rf_state_e     state;
  rf_state_e     state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic          busy;

  // State register; busy is its own flop so it never depends on clr_i
  // combinationally.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= RF_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      busy  <= (state_next == RF_SWEEP);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    unique case (state)
      RF_IDLE: begin
        if (clr_i) begin
          state_next = RF_SWEEP;
          ptr_next   = FIRST;
        end
      end
      RF_SWEEP: begin
        // The last entry is cleared on the same edge that returns to idle.
        if (ptr == LAST) begin
          state_next = RF_IDLE;
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      default: state_next = RF_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    clr_we_o   = (state == RF_SWEEP);
    clr_addr_o = ptr;
  end

  assign busy_o = busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read / single-write register file for the
// ID stage, with optional hardwired zero entry, write-to-read bypass,
// optional registered read, and an incremental clear sweep.
//   clk_i     : clock, all state changes on posedge
//   rst_i     : synchronous active-low reset; zeroes every entry
//   rd_addr_i : NUM_RD packed read addresses, port k at [k*AW +: AW]
//   rd_data_o : NUM_RD packed read data, port k at [k*DW +: DW]
//   wr_en_i   : write enable (dropped while busy_o is high)
//   wr_addr_i : write address
//   wr_data_i : write data
//   clr_i     : pulse to start a clear sweep
//   busy_o    : high while the clear sweep runs
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = rf_aw(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int READ_REG = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD*DW-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 clr_i,
  output logic                 busy_o
);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be a power of two >= 2");
  end

  logic [DW-1:0] mem [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_zero;
  logic          we_eff;

  regfile_clear_fsm #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_clear_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign busy_o = busy;

  // Writes to the hardwired zero entry are dropped here, so entry 0 stays
  // zero in storage as well as on the read path.
  assign wr_zero = (ZERO_REG != 0) && (wr_addr_i == '0);
  assign we_eff  = wr_en_i && !busy && !wr_zero;

  // Storage update. The sweep and a functional write never coincide:
  // we_eff is gated by busy, and clr_we is only asserted while busy.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we_eff) mem[wr_addr_i] <= wr_data_i;
      if (clr_we) mem[clr_addr]  <= '0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] sel;

    assign addr = rd_addr_i[k*AW +: AW];

    // Read select: zero entry, then same-cycle bypass, then storage.
    always_comb begin
      if ((ZERO_REG != 0) && (addr == '0)) begin
        sel = '0;
      end else if (we_eff && (wr_addr_i == addr)) begin
        sel = wr_data_i;
      end else begin
        sel = mem[addr];
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [DW-1:0] rd_data_p1;

      // Stage p0 -> p1: the selection made at the address sample is held
      // for the following cycle.
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          rd_data_p1 <= '0;
        end else begin
          rd_data_p1 <= sel;
        end
      end

      assign rd_data_o[k*DW +: DW] = rd_data_p1;
    end else begin : g_comb
      assign rd_data_o[k*DW +: DW] = sel;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two register files from the same write/clear/reset
// stimulus: a default combinational-read instance and a registered-read
// instance with three read ports. A behavioural model of the entry contents
// and sweep progress predicts every output on every cycle; directed literal
// checks pin the model to hand-computed values.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr;

  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic        busy_a;
  logic [14:0] rd_addr_b;
  logic [95:0] rd_data_b;
  logic        busy_b;

  regfile_mp #(
    .DW(32), .DEPTH(32), .NUM_RD(2), .READ_REG(0), .ZERO_REG(1)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .clr_i(clr), .busy_o(busy_a)
  );

  regfile_mp #(
    .DW(32), .DEPTH(32), .NUM_RD(3), .READ_REG(1), .ZERO_REG(1)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .clr_i(clr), .busy_o(busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [32];
  logic        busy_m;
  int          next_clr;
  logic [31:0] rb_exp [3];
  logic        m_we;
  bit          armed = 1'b0;

  // What a read of address a must return right now.
  function automatic logic [31:0] msel(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && !busy_m && wr_addr != 5'd0 && wr_addr == a) return wr_data;
    return mem_m[a];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
      busy_m   = 1'b0;
      next_clr = 0;
      for (int k = 0; k < 3; k++) rb_exp[k] = 32'd0;
    end else begin
      for (int k = 0; k < 3; k++) rb_exp[k] = msel(rd_addr_b[k*5 +: 5]);
      m_we = wr_en && !busy_m && wr_addr != 5'd0;
      if (busy_m) begin
        mem_m[next_clr] = 32'd0;
        if (next_clr == 31) busy_m = 1'b0;
        else next_clr = next_clr + 1;
      end else if (clr) begin
        busy_m   = 1'b1;
        next_clr = 1;
      end
      if (m_we) mem_m[wr_addr] = wr_data;
    end
    armed = 1'b1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("a_port0", rd_data_a[31:0],  msel(rd_addr_a[4:0]));
      chk("a_port1", rd_data_a[63:32], msel(rd_addr_a[9:5]));
      chk("b_port0", rd_data_b[31:0],  rb_exp[0]);
      chk("b_port1", rd_data_b[63:32], rb_exp[1]);
      chk("b_port2", rd_data_b[95:64], rb_exp[2]);
      chk("a_busy", {31'd0, busy_a}, {31'd0, busy_m});
      chk("b_busy", {31'd0, busy_b}, {31'd0, busy_m});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int cnt;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    step(); step();
    rst = 1'b1;
    rd_addr_a = {5'd0, 5'd5};
    rd_addr_b = {5'd3, 5'd4, 5'd5};
    @(negedge clk);
    chk("rst_a_r5", rd_data_a[31:0], 32'd0);
    chk("rst_b_p1", rd_data_b[63:32], 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);

    // 1: write then read back, r0 reads zero
    step(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step(); wr_en = 1'b0; rd_addr_a = {5'd0, 5'd5};
    @(negedge clk);
    chk("t1_r5", rd_data_a[31:0], 32'hDEADBEEF);
    chk("t1_r0", rd_data_a[63:32], 32'd0);

    // 2: same-cycle bypass on both ports; writes to r0 dropped
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr_a = {5'd7, 5'd7};
    @(negedge clk);
    chk("t2_byp0", rd_data_a[31:0], 32'h12345678);
    chk("t2_byp1", rd_data_a[63:32], 32'h12345678);
    step(); wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = {5'd0, 5'd0};
    @(negedge clk);
    chk("t2_r0_byp", rd_data_a[31:0], 32'd0);
    step(); wr_en = 1'b0; rd_addr_a = {5'd7, 5'd0};
    @(negedge clk);
    chk("t2_r0_after", rd_data_a[31:0], 32'd0);
    chk("t2_r7_stored", rd_data_a[63:32], 32'h12345678);

    // 3: registered read with bypass at the address sample
    step(); wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44444444;
    step(); wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; rd_addr_b = {5'd3, 5'd4, 5'd3};
    step(); wr_en = 1'b0;
    @(negedge clk);
    chk("t3_b0", rd_data_b[31:0],  32'hA5A5A5A5);
    chk("t3_b1", rd_data_b[63:32], 32'h44444444);
    chk("t3_b2", rd_data_b[95:64], 32'hA5A5A5A5);

    // 4: clear sweep
    for (int i = 1; i < 32; i++) begin
      step(); wr_en = 1'b1; wr_addr = i[4:0]; wr_data = 32'(i);
    end
    step(); wr_addr = 5'd1; wr_data = 32'h77; clr = 1'b1; rd_addr_a = {5'd9, 5'd1};
    step(); clr = 1'b0; wr_en = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 40) begin
      cnt++;
      if (cnt == 1) begin
        @(negedge clk);
        chk("t4_wr_with_clr", rd_data_a[31:0], 32'h77);
      end
      if (cnt == 10) begin
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rd_addr_a = {5'd9, 5'd20};
        @(negedge clk);
        chk("t4_partial_r20", rd_data_a[31:0], 32'd20);
        chk("t4_no_bypass_r9", rd_data_a[63:32], 32'd0);
      end
      step(); wr_en = 1'b0;
    end
    chk("t4_busy_len", 32'(cnt), 32'd31);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {i[4:0], i[4:0]};
      @(negedge clk);
      chk("t4_cleared", rd_data_a[31:0], 32'd0);
      step();
    end

    // 5: reset mid-sweep, then clr ignored during a sweep
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAAAA0010;
    step(); wr_addr = 5'd31; wr_data = 32'hAAAA001F;
    step(); wr_en = 1'b0; clr = 1'b1;
    step(); clr = 1'b0;
    for (int c = 1; c < 5; c++) step();
    rd_addr_a = {5'd31, 5'd10};
    @(negedge clk);
    chk("t5_partial_r10", rd_data_a[31:0], 32'hAAAA0010);
    chk("t5_busy_c5", {31'd0, busy_a}, 32'd1);
    rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_after_rst", {31'd0, busy_a}, 32'd0);
    chk("t5_r10_rst", rd_data_a[31:0], 32'd0);
    chk("t5_r31_rst", rd_data_a[63:32], 32'd0);
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 40) begin
      cnt++;
      clr = (cnt == 12);
      step();
    end
    clr = 1'b0;
    chk("t5_clr_ignored_len", 32'(cnt), 32'd31);

    // 6: reset has priority over a simultaneous write
    step(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
    step(); wr_data = 32'h55; rst = 1'b0;
    step(); step();
    rst = 1'b1; wr_en = 1'b0; rd_addr_a = {5'd2, 5'd2}; rd_addr_b = {5'd2, 5'd2, 5'd2};
    @(negedge clk);
    chk("t6_a_r2", rd_data_a[31:0], 32'd0);
    step();
    @(negedge clk);
    chk("t6_b_r2", rd_data_b[31:0], 32'd0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
